// File: rtl/alu_pkg.sv
// Shared opcode and sequencer-state types for the bit-serial ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_PASSB = 3'b000,
      ALU_ADD   = 3'b010,
      ALU_SUB   = 3'b011,
      ALU_AND   = 3'b100,
      ALU_OR    = 3'b101,
      ALU_XOR   = 3'b110
   } alu_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } ser_state_t;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Issue/result bus of the bit-serial ALU. Handshake: a request is accepted on a rising clk edge
// where start=1 and ready=1; done is a one-cycle pulse marking result and flags valid.
interface alu_serial_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   modport master (
      output start, op, a_in, b_in,
      input  ready, busy, done, result, flag_n, flag_z, flag_c, flag_v
   );

   modport slave (
      input  start, op, a_in, b_in,
      output ready, busy, done, result, flag_n, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/alu_1bit.sv
// One-bit ALU slice. en[0] inverts B on the arithmetic path so 011 computes A+~B+Cin.
module alu_1bit
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] en,
   output logic       y,
   output logic       cout
);

   logic bx;

   always_comb begin
      bx   = b ^ en[0];
      y    = 1'b0;
      cout = 1'b0;
      case (en)
         ALU_PASSB: y = b;
         ALU_ADD, ALU_SUB: begin
            y    = a ^ bx ^ cin;
            cout = (a & bx) | (a & cin) | (bx & cin);
         end
         ALU_AND:   y = a & b;
         ALU_OR:    y = a | b;
         ALU_XOR:   y = a ^ b;
         default:   y = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one alu_1bit slice LSB first over WIDTH cycles.
// Optional flags: define ALU_SERIAL_FLAGS_EN to build the N/Z/C/V flag registers.
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   alu_serial_ctrl_if.slave    bus,
   output ser_state_t          dbg_state
);

   localparam int CW = $clog2(WIDTH);

   ser_state_t       state;
   logic [CW-1:0]    count;
   logic             carry;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] result_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             slice_y;
   logic             slice_cout;
   logic             last_run;
   logic [WIDTH-1:0] next_shadow;

   alu_1bit u_slice (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .en   (op_q),
      .y    (slice_y),
      .cout (slice_cout)
   );

   // Slice output enters at the MSB so bit 0 reaches result[0] after WIDTH shifts.
   assign next_shadow = {slice_y, shadow[WIDTH-1:1]};
   assign last_run    = (state == S_RUN) && (count == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         count    <= '0;
         carry    <= 1'b0;
         op_q     <= 3'b000;
         a_sh     <= '0;
         b_sh     <= '0;
         shadow   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh    <= bus.a_in;
                  b_sh    <= bus.b_in;
                  op_q    <= bus.op;
                  count   <= '0;
                  carry   <= (bus.op == ALU_SUB);
                  state   <= S_RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               shadow <= next_shadow;
               carry  <= slice_cout;
               count  <= count + 1'b1;
               if (last_run) begin
                  result_q <= next_shadow;
                  state    <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready  = ready_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign dbg_state  = state;

`ifdef ALU_SERIAL_FLAGS_EN
   logic is_arith;
   logic flag_n_q, flag_z_q, flag_c_q, flag_v_q;

   assign is_arith = (op_q == ALU_ADD) || (op_q == ALU_SUB);

   // Overflow is carry into the MSB xor carry out of it, both visible in the last cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
      end else if (last_run) begin
         flag_n_q <= next_shadow[WIDTH-1];
         flag_z_q <= (next_shadow == '0);
         flag_c_q <= is_arith & slice_cout;
         flag_v_q <= is_arith & (carry ^ slice_cout);
      end
   end

   assign bus.flag_n = flag_n_q;
   assign bus.flag_z = flag_z_q;
   assign bus.flag_c = flag_c_q;
   assign bus.flag_v = flag_v_q;
`else
   assign bus.flag_n = 1'b0;
   assign bus.flag_z = 1'b0;
   assign bus.flag_c = 1'b0;
   assign bus.flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl (WIDTH=8): directed corner cases plus random ops against an arithmetic model.
module tb_alu_serial_ctrl;
   import alu_pkg::*;

   localparam int W = 8;
`ifdef ALU_SERIAL_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   logic       clk;
   logic       reset;
   ser_state_t dbg_state;
   int         total;
   int         bad;
   logic [11:0] exp_q[$];

   alu_serial_ctrl_if #(.WIDTH(W)) bus ();

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {v, c, z, n, result} from plain 2's-complement arithmetic.
   function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int   s;
      logic [7:0] r;
      logic c, v;
      r = 8'h00; c = 1'b0; v = 1'b0;
      case (op)
         3'b000: r = b;
         3'b010: begin
            s = int'(a) + int'(b);
            r = s[7:0]; c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         3'b011: begin
            s = int'(a) + (255 - int'(b)) + 1;
            r = s[7:0]; c = s[8];
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         3'b100: r = a & b;
         3'b101: r = a | b;
         3'b110: r = a ^ b;
         default: r = 8'h00;
      endcase
      return {v, c, (r == 8'h00), r[7], r};
   endfunction

   function automatic logic [3:0] flags_now();
      return {bus.flag_v, bus.flag_c, bus.flag_z, bus.flag_n};
   endfunction

   task automatic check_result(input string tag);
      logic [11:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_result"}, 32'(bus.result), 32'(e[7:0]));
         check({tag, "_flags"}, 32'(flags_now()), 32'(e[11:8] & {4{FLAGS_ON}}));
      end
   endtask

   // Counts cycles after the accept edge until done is seen (bounded).
   task automatic wait_done(input string tag, input int first_n);
      int n;
      n = first_n;
      while (!bus.done && n < 30) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd9);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n;
      exp_q.push_back(model(op, a, b));
      n = 0;
      while (!bus.ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op = 3'($urandom); bus.a_in = 8'($urandom); bus.b_in = 8'($urandom);
      check({tag, "_busy"}, 32'({bus.busy, bus.ready}), 32'b10);
      wait_done(tag, 1);
      check_result(tag);
      @(negedge clk);
      check({tag, "_back_idle"}, 32'({bus.ready, bus.done}), 32'b10);
   endtask

   initial begin
      bool_seen_init();
   end

   function automatic void bool_seen_init();
      total = 0;
      bad   = 0;
   endfunction

   initial begin
      logic seen;
      int   n;
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 3'b000; bus.a_in = '0; bus.b_in = '0;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      check("rst_hs", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_flags", 32'(flags_now()), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // directed corner cases
      run_op("add_ovf", 3'b010, 8'h7F, 8'h01);
      run_op("sub_eq",  3'b011, 8'h05, 8'h05);
      run_op("sub_brw", 3'b011, 8'h00, 8'h01);
      run_op("sub_ovf", 3'b011, 8'h80, 8'h01);
      run_op("and",     3'b100, 8'hF0, 8'h3C);
      run_op("or",      3'b101, 8'hF0, 8'h3C);
      run_op("xor",     3'b110, 8'hF0, 8'h3C);
      run_op("passb",   3'b000, 8'h00, 8'hA5);
      run_op("zero7",   3'b111, 8'hFF, 8'hFF);
      run_op("zero1",   3'b001, 8'h12, 8'h34);
      run_op("add_cy",  3'b010, 8'hFF, 8'h01);

      // start held high through RUN with different operands: only re-accepted after DONE
      exp_q.push_back(model(3'b010, 8'h7F, 8'h01));
      exp_q.push_back(model(3'b110, 8'hF0, 8'h3C));
      bus.start = 1'b1; bus.op = 3'b010; bus.a_in = 8'h7F; bus.b_in = 8'h01;
      @(negedge clk);
      bus.op = 3'b110; bus.a_in = 8'hF0; bus.b_in = 8'h3C;
      wait_done("hold1", 1);
      check_result("hold1");
      @(negedge clk);
      check("hold_idle", 32'(bus.ready), 32'd1);
      @(negedge clk);
      bus.start = 1'b0;
      check("hold2_busy", 32'(bus.busy), 32'd1);
      wait_done("hold2", 1);
      check_result("hold2");
      @(negedge clk);

      // reset during RUN cycle 4 aborts without a done pulse
      bus.start = 1'b1; bus.op = 3'b010; bus.a_in = 8'h01; bus.b_in = 8'h02;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_running", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_state", 32'(dbg_state), 32'(S_IDLE));
      check("abort_hs", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
      check("abort_result", 32'(bus.result), 32'd0);
      check("abort_flags", 32'(flags_now()), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen), 32'd0);

      // randomized ops
      for (int i = 0; i < 30; i++) begin
         run_op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         n = $urandom_range(0, 2);
         repeat (n) @(negedge clk);
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
